// File: rtl/uart_tx.sv
// UART transmitter: accepts words over valid/ready and serialises them as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx
);

  localparam int P_DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int P_DIV_W = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam int P_BIT_W = 4;
  // Unknown parity codes fall back to no parity.
  localparam int P_MODE  = (P_UART_CHECK == 1 || P_UART_CHECK == 2) ? P_UART_CHECK : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } t_state;

  t_state                         r_state, w_state_next;
  logic   [P_DIV_W-1:0]           r_div, w_div_next;
  logic   [P_BIT_W-1:0]           r_bit, w_bit_next;
  logic   [P_UART_DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                           r_parity, w_parity_next;
  logic                           r_tx, w_tx_next;
  logic                           r_ready, w_ready_next;
  logic                           w_wrap;

  assign w_wrap          = (r_div == P_DIV_W'(P_DIV - 1));
  assign o_uart_tx       = r_tx;
  assign o_user_tx_ready = r_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_div_next;
      r_bit    <= w_bit_next;
      r_shift  <= w_shift_next;
      r_parity <= w_parity_next;
      r_tx     <= w_tx_next;
      r_ready  <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_div_next    = r_div;
    w_bit_next    = r_bit;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    if (r_state != S_IDLE) begin
      w_div_next = w_wrap ? '0 : r_div + P_DIV_W'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (i_user_tx_valid) begin
          w_state_next  = S_START;
          w_div_next    = '0;
          w_bit_next    = '0;
          w_shift_next  = i_user_tx_data;
          // Odd parity inverts the data XOR so the total count of ones is odd.
          w_parity_next = (^i_user_tx_data) ^ (P_MODE == 1);
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state_next = S_DATA;
          w_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_bit == P_BIT_W'(P_UART_DATA_WIDTH - 1)) begin
            w_state_next = (P_MODE != 0) ? S_PARITY : S_STOP;
            w_bit_next   = '0;
          end else begin
            w_bit_next   = r_bit + P_BIT_W'(1);
            w_shift_next = r_shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state_next = S_STOP;
          w_bit_next   = '0;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          if (r_bit == P_BIT_W'(P_UART_STOP_WIDTH - 1)) begin
            w_state_next = S_IDLE;
            w_bit_next   = '0;
          end else begin
            w_bit_next = r_bit + P_BIT_W'(1);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the line and ready are registered.
  always_comb begin
    w_tx_next    = 1'b1;
    w_ready_next = 1'b0;
    case (w_state_next)
      S_IDLE:   w_ready_next = 1'b1;
      S_START:  w_tx_next    = 1'b0;
      S_DATA:   w_tx_next    = w_shift_next[0];
      S_PARITY: w_tx_next    = w_parity_next;
      default:  w_tx_next    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8O1, 8E1, 8N2) driven from a shared
// stimulus; a time-based frame model feeds per-channel expectation queues.
module tb_uart_tx;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       rdy   [4];
  logic       line  [4];

  int cyc = 0;
  int m_end [4];
  logic [7:0] fifo_w [4][16];
  int fifo_a [4][16];
  int wp [4];
  int rp [4];
  int stim_to = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic       act   [4];
  int         st    [4];
  logic [7:0] cur_w [4];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int CHK = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
      localparam int STP = (gi == 3) ? 2 : 1;
      uart_tx #(
        .P_SYSTEM_CLK(1_000_000),
        .P_UART_BUADRATE(100_000),
        .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(STP),
        .P_UART_CHECK(CHK)
      ) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_user_tx_data(data[gi]),
        .i_user_tx_valid(valid[gi]),
        .o_user_tx_ready(rdy[gi]),
        .o_uart_tx(line[gi])
      );
    end
  endgenerate

  function automatic int frame_len(input int c);
    return DIV * (1 + 8 + ((c == 1 || c == 2) ? 1 : 0) + ((c == 3) ? 2 : 1));
  endfunction

  // Line level for bit slot 'slot' of a frame carrying w on channel c.
  function automatic logic exp_bit(input int c, input logic [7:0] w, input int slot);
    int ones;
    ones = $countones(w);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return w[slot-1];
    if (slot == 9 && c == 1) return (ones % 2 == 0);
    if (slot == 9 && c == 2) return (ones % 2 == 1);
    return 1'b1;
  endfunction

  function automatic void check(input string name, input int c, input logic [31:0] got,
                                input logic [31:0] exp, input int n);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d cycle %0d: got %0d expected %0d", name, c, n, got, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a word is taken when valid is high and the previous frame
  // has ended; the channel is then busy for exactly one frame length.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) m_end[c] <= 0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (valid[c] && (cyc >= m_end[c])) begin
          fifo_w[c][wp[c] % 16] <= data[c];
          fifo_a[c][wp[c] % 16] <= cyc + 1;
          wp[c]                 <= wp[c] + 1;
          m_end[c]              <= cyc + 1 + frame_len(c);
        end
      end
    end
  end

  initial begin : monitor
    int   n;
    int   pos;
    logic prev_rst;
    prev_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      act[c] = 1'b0;
      st[c]  = 0;
      cur_w[c] = 8'h00;
    end
    forever begin
      @(negedge clk or posedge rst);
      if (rst && !prev_rst) begin
        prev_rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
          check("async_rst_line", c, 32'(line[c]), 32'd1, cyc);
          check("async_rst_ready", c, 32'(rdy[c]), 32'd1, cyc);
          act[c] = 1'b0;
          rp[c]  = wp[c];
        end
      end else if (!clk) begin
        prev_rst = rst;
        n = cyc;
        if (done || n > 60000) begin
          check("watchdog", -1, 32'(n > 60000), 32'd0, n);
          check("stim_timeouts", -1, 32'(stim_to), 32'd0, n);
          for (int c = 0; c < 4; c++)
            check("drain", c, 32'(rp[c] == wp[c] && !act[c]), 32'd1, n);
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $finish;
        end
        for (int c = 0; c < 4; c++) begin
          check("ready", c, 32'(rdy[c]), 32'(rst ? 1 : (n >= m_end[c])), n);
          if (rst) begin
            check("rst_line", c, 32'(line[c]), 32'd1, n);
            act[c] = 1'b0;
            rp[c]  = wp[c];
          end else begin
            if (!act[c]) begin
              if (line[c] === 1'b0) begin
                if (rp[c] == wp[c]) begin
                  check("spurious_start", c, 32'(line[c]), 32'd1, n);
                end else begin
                  cur_w[c] = fifo_w[c][rp[c] % 16];
                  check("start_time", c, 32'(n), 32'(fifo_a[c][rp[c] % 16]), n);
                  rp[c]  = rp[c] + 1;
                  act[c] = 1'b1;
                  st[c]  = n;
                end
              end else if (rp[c] != wp[c] && n > fifo_a[c][rp[c] % 16]) begin
                check("start_timeout", c, 32'(n), 32'(fifo_a[c][rp[c] % 16]), n);
                rp[c] = rp[c] + 1;
              end
            end
            if (act[c]) begin
              pos = n - st[c];
              check("line_bit", c, 32'(line[c]), 32'(exp_bit(c, cur_w[c], pos / DIV)), n);
              if (pos == frame_len(c) - 1) begin
                act[c] = 1'b0;
                $display("ch%0d frame 0x%02h completed at cycle %0d", c, cur_w[c], n);
              end
            end
          end
        end
      end
    end
  end

  task automatic send(input int ch, input logic [7:0] w);
    int t;
    t = 0;
    @(negedge clk);
    data[ch]  = w;
    valid[ch] = 1'b1;
    while (!rdy[ch] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) stim_to++;
    @(negedge clk);
    valid[ch] = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    int t;
    int c;
    rst  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
      wp[i]    = 0;
      rp[i]    = 0;
    end
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Directed frames on each framing variant.
    send(0, 8'h55);
    send(1, 8'h03);
    send(2, 8'h07);
    send(2, 8'h00);
    send(3, 8'hFF);
    idle_wait(150);

    // Back-to-back with valid held; data changes right after first acceptance.
    @(negedge clk);
    data[0]  = 8'hA5;
    valid[0] = 1'b1;
    t = 0;
    while (!rdy[0] && t < 500) begin @(negedge clk); t++; end
    @(negedge clk);
    data[0] = 8'h3C;
    while (!rdy[0] && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) stim_to++;
    @(negedge clk);
    valid[0] = 1'b0;
    idle_wait(150);

    // Valid pulsed while busy must be ignored.
    send(0, 8'h12);
    idle_wait(30);
    data[0]  = 8'hEE;
    valid[0] = 1'b1;
    idle_wait(3);
    valid[0] = 1'b0;
    idle_wait(150);

    // Randomised words on random channels with random gaps.
    for (int i = 0; i < 24; i++) begin
      c = int'($urandom_range(0, 3));
      idle_wait(int'($urandom_range(0, 5)));
      send(c, 8'($urandom));
    end
    idle_wait(150);

    // Reset during data bit 3 of an all-zero word, then a clean frame.
    send(0, 8'h00);
    idle_wait(44);
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    idle_wait(5);
    send(0, 8'h81);
    idle_wait(150);
    done = 1'b1;
  end

endmodule
